// File: rtl/db_pkg.sv
// db_pkg: shared state encoding and counter sizing for the multi-channel debouncer
package db_pkg;
    // bit 1 = accepted level, bits differ = checking a candidate level
    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] CHK_HI    = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b11;
    localparam logic [1:0] CHK_LO    = 2'b10;

    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles);
    endfunction
endpackage

// File: rtl/db_channel.sv
// db_channel: one debounce channel (sync chain, acceptance FSM, counter, edge pulses)
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-low reset
//   in     in  raw asynchronous input
//   db_out out debounced level
//   rise   out one-cycle pulse when db_out goes 0->1
//   fall   out one-cycle pulse when db_out goes 1->0
//   busy   out channel is checking a candidate level
module db_channel
    import db_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter logic INIT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic db_out,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rise_n, fall_n, lvl, chk, dif, accept;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) sync <= {SYNC_STAGES{INIT}};
            else      sync <= SYNC_STAGES'({sync, in});
        end
        assign s = sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT ? STABLE_HI : STABLE_LO;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    // lvl is the accepted level; dif means the synced input disagrees with it
    assign lvl    = state[1];
    assign chk    = state == CHK_HI || state == CHK_LO;
    assign dif    = s ^ lvl;
    assign accept = chk && dif && cnt == LAST;

    always_comb begin
        state_n = !dif   ? (lvl ? STABLE_HI : STABLE_LO) :
                  !chk   ? (lvl ? CHK_LO : CHK_HI) :
                  accept ? (lvl ? STABLE_LO : STABLE_HI) : state;
        // entering a check from a stable state starts at cnt=0 -> 1
        cnt_n   = (dif && !accept) ? cnt + 1'b1 : '0;
    end

    always_comb begin
        rise_n = accept && !lvl;
        fall_n = accept && lvl;
        busy   = chk;
    end

    // the level bit of the state register is the debounced output
    assign db_out = lvl;
endmodule

// File: rtl/db_multi.sv
// db_multi: N independent debounce channels with per-channel edge pulses and a shared busy flag
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-low reset
//   in     in  [CH] raw inputs, bit i = channel i
//   db_out out [CH] debounced levels
//   rise   out [CH] one-cycle 0->1 pulses
//   fall   out [CH] one-cycle 1->0 pulses
//   busy   out any channel checking a candidate level
module db_multi
    import db_pkg::*;
#(
    parameter int   CH            = 1,
    parameter int   STABLE_CYCLES = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter logic INIT          = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] db_out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          busy
);
    logic [CH-1:0] ch_busy;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        db_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .INIT         (INIT)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .in    (in[g]),
            .db_out(db_out[g]),
            .rise  (rise[g]),
            .fall  (fall[g]),
            .busy  (ch_busy[g])
        );
    end

    assign busy = |ch_busy;
endmodule

// File: tb/tb_db_multi.sv
// tb_db_multi: randomized and directed scoreboard bench for db_multi
module tb_db_multi;
    localparam int CH     = 2;
    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] in  = 2'b11;
    logic [CH-1:0] db_out, rise, fall;
    logic          busy;

    db_multi #(.CH(CH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .INIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in(in), .db_out(db_out), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [6:0]    exp_q[$];
    logic [CH-1:0] hist[$];
    logic [CH-1:0] lvl, s_v, r_v, f_v;
    int            run[CH];
    logic          b_v;

    // Reference: the synced input is the raw sample from SYNC edges ago; a channel
    // flips once that input has disagreed with its level for STABLE samples in a row.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist = {};
            repeat (SYNC) hist.push_back('0);
            lvl = '0;
            for (int c = 0; c < CH; c++) run[c] = 0;
            if (exp_q.size() > 0) exp_q[$] = '0;
            else exp_q.push_back('0);
        end else begin
            hist.push_back(in);
            s_v = hist.pop_front();
            r_v = '0;
            f_v = '0;
            b_v = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (s_v[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == STABLE) begin
                        lvl[c] = s_v[c];
                        run[c] = 0;
                        if (s_v[c]) r_v[c] = 1'b1;
                        else f_v[c] = 1'b1;
                    end
                end else run[c] = 0;
                if (run[c] > 0) b_v = 1'b1;
            end
            exp_q.push_back({lvl, r_v, f_v, b_v});
        end
    end

    logic [6:0] e;
    always @(negedge clk) begin
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({db_out, rise, fall, busy} !== e) begin
                errors++;
                $display("FAIL outputs @%0t: db_out=%b rise=%b fall=%b busy=%b, required db_out=%b rise=%b fall=%b busy=%b",
                         $time, db_out, rise, fall, busy, e[6:5], e[4:3], e[2:1], e[0]);
            end
        end
    end

    task automatic drive(input logic [CH-1:0] v, input int n);
        in = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        drive(2'b00, 8);
        drive(2'b01, 10);
        drive(2'b00, 10);
        drive(2'b01, 1); drive(2'b00, 3);
        drive(2'b01, 2); drive(2'b00, 3);
        drive(2'b01, 3); drive(2'b00, 8);
        drive(2'b01, 10);
        drive(2'b00, 2); drive(2'b01, 1); drive(2'b00, 10);
        drive(2'b11, 10);
        drive(2'b00, 10);
        drive(2'b10, 4);
        pulse_reset(2);
        drive(2'b10, 10);
        repeat (80) begin
            if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
            drive(2'($urandom_range(0, 3)), $urandom_range(1, 7));
        end
        drive(2'b00, 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
